// File: rtl/image_rom_arbiter.sv
// Shares the image ROM read port: VGA fetcher has strict priority, the aux burst reader fills idle slots.
// Optional build macro ARB_PERF_EN adds stall/burst performance counters.
module image_rom_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk_vga,
    input  logic              reset,
    input  logic              i_vga_req,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic [DATA_W-1:0] o_vga_data,
    output logic              o_vga_valid,
    input  logic              i_aux_req,
    input  logic [ADDR_W-1:0] i_aux_addr,
    input  logic [LEN_W-1:0]  i_aux_len,
    output logic              o_aux_ack,
    output logic              o_aux_busy,
    output logic [DATA_W-1:0] o_aux_data,
    output logic              o_aux_valid,
    output logic              o_aux_last,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data
`ifdef ARB_PERF_EN
    ,
    input  logic              i_perf_clr,
    output logic [15:0]       o_perf_stall,
    output logic [15:0]       o_perf_bursts
`endif
);

    localparam int unsigned LAST_STG = ROM_LAT - 1;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_V, OWN_A} own_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    w_cnt_nxt;
    logic [ADDR_W-1:0]   r_rom_addr_hold;
    logic [ADDR_W-1:0]   w_rom_addr;
    own_t                w_own;
    logic                w_issue_last;
    logic                w_aux_ack;

    own_t                r_tag_own  [ROM_LAT];
    logic                r_tag_last [ROM_LAT];

    logic [DATA_W-1:0]   r_vga_data;
    logic                r_vga_valid;
    logic [DATA_W-1:0]   r_aux_data;
    logic                r_aux_valid;
    logic                r_aux_last;

    // Slot ownership, address select and burst FSM next state
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_cnt_nxt    = r_cnt;
        w_rom_addr   = r_rom_addr_hold;
        w_own        = OWN_NONE;
        w_issue_last = 1'b0;
        w_aux_ack    = 1'b0;
        if (i_vga_req) begin
            w_own      = OWN_V;
            w_rom_addr = i_vga_addr;
        end
        case (r_state)
            S_IDLE: begin
                if (i_aux_req) begin
                    w_aux_ack   = 1'b1;
                    w_addr_nxt  = i_aux_addr;
                    w_cnt_nxt   = i_aux_len;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (!i_vga_req) begin
                    w_own      = OWN_A;
                    w_rom_addr = r_addr;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    if (r_cnt == '0) begin
                        w_issue_last = 1'b1;
                        w_state_nxt  = S_DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt - LEN_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (r_aux_valid && r_aux_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, burst registers, tag pipe and returned-data registers
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_cnt           <= '0;
            r_rom_addr_hold <= '0;
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                r_tag_own[i]  <= OWN_NONE;
                r_tag_last[i] <= 1'b0;
            end
            r_vga_data  <= '0;
            r_vga_valid <= 1'b0;
            r_aux_data  <= '0;
            r_aux_valid <= 1'b0;
            r_aux_last  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_addr          <= w_addr_nxt;
            r_cnt           <= w_cnt_nxt;
            r_rom_addr_hold <= w_rom_addr;
            r_tag_own[0]    <= w_own;
            r_tag_last[0]   <= w_issue_last;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                r_tag_own[i]  <= r_tag_own[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
            end
            r_vga_valid <= (r_tag_own[LAST_STG] == OWN_V);
            r_aux_valid <= (r_tag_own[LAST_STG] == OWN_A);
            r_aux_last  <= (r_tag_own[LAST_STG] == OWN_A) && r_tag_last[LAST_STG];
            if (r_tag_own[LAST_STG] == OWN_V) begin
                r_vga_data <= i_rom_data;
            end
            if (r_tag_own[LAST_STG] == OWN_A) begin
                r_aux_data <= i_rom_data;
            end
        end
    end

    assign o_rom_addr  = reset ? '0 : w_rom_addr;
    assign o_aux_ack   = w_aux_ack & ~reset;
    // Busy falls in the same cycle the final word strobes
    assign o_aux_busy  = (r_state == S_BURST) ||
                         ((r_state == S_DRAIN) && !(r_aux_valid && r_aux_last));
    assign o_vga_data  = r_vga_data;
    assign o_vga_valid = r_vga_valid;
    assign o_aux_data  = r_aux_data;
    assign o_aux_valid = r_aux_valid;
    assign o_aux_last  = r_aux_last;

`ifdef ARB_PERF_EN
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_bursts;

    // Saturating counters; clear has priority over a same-cycle increment
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            r_perf_stall  <= '0;
            r_perf_bursts <= '0;
        end else if (i_perf_clr) begin
            r_perf_stall  <= '0;
            r_perf_bursts <= '0;
        end else begin
            if ((r_state == S_BURST) && i_vga_req && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'(1);
            end
            if (w_aux_ack && (r_perf_bursts != 16'hFFFF)) begin
                r_perf_bursts <= r_perf_bursts + 16'(1);
            end
        end
    end

    assign o_perf_stall  = r_perf_stall;
    assign o_perf_bursts = r_perf_bursts;
`endif

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Scoreboard bench for image_rom_arbiter with a 1-cycle behavioural ROM model.
module tb_image_rom_arbiter;

    logic        clk_vga = 1'b0;
    logic        reset;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [7:0]  vga_data;
    logic        vga_valid;
    logic        aux_req;
    logic [15:0] aux_addr;
    logic [7:0]  aux_len;
    logic        aux_ack;
    logic        aux_busy;
    logic [7:0]  aux_data;
    logic        aux_valid;
    logic        aux_last;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
`ifdef ARB_PERF_EN
    logic        perf_clr;
    logic [15:0] perf_stall;
    logic [15:0] perf_bursts;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0] vq   [$];
    int         vcyc [$];
    logic [8:0] aq   [$];

    image_rom_arbiter dut (
        .clk_vga    (clk_vga),
        .reset      (reset),
        .i_vga_req  (vga_req),
        .i_vga_addr (vga_addr),
        .o_vga_data (vga_data),
        .o_vga_valid(vga_valid),
        .i_aux_req  (aux_req),
        .i_aux_addr (aux_addr),
        .i_aux_len  (aux_len),
        .o_aux_ack  (aux_ack),
        .o_aux_busy (aux_busy),
        .o_aux_data (aux_data),
        .o_aux_valid(aux_valid),
        .o_aux_last (aux_last),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data)
`ifdef ARB_PERF_EN
        ,
        .i_perf_clr   (perf_clr),
        .o_perf_stall (perf_stall),
        .o_perf_bursts(perf_bursts)
`endif
    );

    always #5 clk_vga = ~clk_vga;
    always @(posedge clk_vga) cyc <= cyc + 1;

    function automatic logic [7:0] rom_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    always @(posedge clk_vga) rom_data <= rom_f(rom_addr);

    // Pop and compare every returned word
    always @(negedge clk_vga) begin
        logic [7:0] ev;
        logic [8:0] ea;
        int         ec;
        if (!reset && vga_valid) begin
            vectors++;
            if (vq.size() == 0) begin
                miscompares++;
                $display("FAIL vga_unexpected: got data=%h, required no strobe", vga_data);
            end else begin
                ev = vq.pop_front();
                ec = vcyc.pop_front();
                if (vga_data !== ev || cyc !== ec + 2) begin
                    miscompares++;
                    $display("FAIL vga_word: got data=%h cyc=%0d, required data=%h cyc=%0d",
                             vga_data, cyc, ev, ec + 2);
                end
            end
        end
        if (!reset && aux_valid) begin
            vectors++;
            if (aq.size() == 0) begin
                miscompares++;
                $display("FAIL aux_unexpected: got data=%h, required no strobe", aux_data);
            end else begin
                ea = aq.pop_front();
                if ({aux_data, aux_last} !== ea || (aux_last && aux_busy !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL aux_word: got data=%h last=%b busy=%b, required data=%h last=%b busy=0",
                             aux_data, aux_last, aux_busy, ea[8:1], ea[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic vga_issue(input logic [15:0] a);
        vga_req  = 1'b1;
        vga_addr = a;
        vq.push_back(rom_f(a));
        vcyc.push_back(cyc);
        #1;
        vectors++;
        if (rom_addr !== a) begin
            miscompares++;
            $display("FAIL vga_rom_addr: got %h, required %h", rom_addr, a);
        end
    endtask

    task automatic start_burst(input logic [15:0] a, input logic [7:0] len);
        aux_req  = 1'b1;
        aux_addr = a;
        aux_len  = len;
        #1;
        vectors++;
        if (aux_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL aux_ack_accept: got %b, required 1", aux_ack);
        end
        for (int i = 0; i <= int'(len); i++) begin
            aq.push_back({rom_f(16'(a + 16'(i))), (i == int'(len))});
        end
        tick();
        aux_req = 1'b0;
        #1;
        vectors++;
        if (aux_ack !== 1'b0 || aux_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL aux_ack_pulse: got ack=%b busy=%b, required ack=0 busy=1", aux_ack, aux_busy);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((aq.size() != 0 || vq.size() != 0 || aux_busy) && n < 2000) begin
            tick();
            n++;
        end
        tick();
        vectors++;
        if (n >= 2000) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d words outstanding, required 0", name, aq.size() + vq.size());
        end
    endtask

    task automatic check_addr(input string name, input logic [15:0] a);
        vectors++;
        if (rom_addr !== a) begin
            miscompares++;
            $display("FAIL %s: got rom_addr=%h, required %h", name, rom_addr, a);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        vga_req  = 1'b0;
        vga_addr = '0;
        aux_req  = 1'b0;
        aux_addr = '0;
        aux_len  = '0;
`ifdef ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        tick();
        tick();
        vectors++;
        if ({vga_valid, aux_valid, aux_last, aux_ack, aux_busy} !== 5'b0 ||
            vga_data !== 8'h00 || aux_data !== 8'h00 || rom_addr !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state: got vv=%b av=%b al=%b ack=%b busy=%b vd=%h ad=%h ra=%h, required all 0",
                     vga_valid, aux_valid, aux_last, aux_ack, aux_busy, vga_data, aux_data, rom_addr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_vga_only();
        for (int i = 0; i < 3; i++) begin
            vga_issue(16'(i));
            tick();
        end
        vga_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        wait_done("vga_only");
    endtask

    task automatic test_burst_idle();
        start_burst(16'h0100, 8'd3);
        check_addr("burst_first_addr", 16'h0100);
        wait_done("burst_idle");
    endtask

    task automatic test_preempt();
        start_burst(16'h2000, 8'd7);
        check_addr("preempt_a0", 16'h2000);
        tick();
        check_addr("preempt_a1", 16'h2001);
        tick();
        for (int i = 0; i < 3; i++) begin
            vga_issue(16'h1234 + 16'(i * 16'h0101));
            tick();
        end
        vga_req = 1'b0;
        #1;
        check_addr("preempt_resume", 16'h2002);
        wait_done("preempt");
    endtask

    task automatic test_wrap();
        start_burst(16'hFFFE, 8'd3);
        wait_done("wrap");
    endtask

    task automatic test_reset_mid_burst();
        start_burst(16'h3000, 8'd15);
        tick();
        tick();
        reset = 1'b1;
        aq.delete();
        tick();
        vectors++;
        if ({vga_valid, aux_valid, aux_last, aux_ack, aux_busy} !== 5'b0 || rom_addr !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_burst: got vv=%b av=%b al=%b ack=%b busy=%b ra=%h, required all 0",
                     vga_valid, aux_valid, aux_last, aux_ack, aux_busy, rom_addr);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        start_burst(16'h0040, 8'd2);
        wait_done("post_reset_burst");
    endtask

    task automatic test_back_to_back();
        start_burst(16'h0500, 8'd0);
        wait_done("single_word");
        for (int i = 0; i < 6; i++) begin
            vga_issue(16'hA000 + 16'(i));
            tick();
        end
        vga_req = 1'b0;
        start_burst(16'h0700, 8'd4);
        wait_done("back_to_back");
    endtask

`ifdef ARB_PERF_EN
    task automatic test_perf();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        start_burst(16'h0800, 8'd3);
        for (int i = 0; i < 5; i++) begin
            vga_issue(16'hB000 + 16'(i));
            tick();
        end
        vga_req = 1'b0;
        wait_done("perf_b1");
        start_burst(16'h0900, 8'd3);
        wait_done("perf_b2");
        vectors++;
        if (perf_stall !== 16'd5 || perf_bursts !== 16'd2) begin
            miscompares++;
            $display("FAIL perf_counts: got stall=%0d bursts=%0d, required 5 and 2", perf_stall, perf_bursts);
        end
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        vectors++;
        if (perf_stall !== 16'd0 || perf_bursts !== 16'd0) begin
            miscompares++;
            $display("FAIL perf_clr: got stall=%0d bursts=%0d, required 0 and 0", perf_stall, perf_bursts);
        end
        start_burst(16'h0A00, 8'd1);
        vga_req  = 1'b1;
        vga_addr = 16'hC000;
        for (int i = 0; i < 65540; i++) begin
            vq.push_back(rom_f(16'hC000));
            vcyc.push_back(cyc);
            tick();
        end
        vga_req = 1'b0;
        vectors++;
        if (perf_stall !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL perf_saturate: got stall=%h, required FFFF", perf_stall);
        end
        wait_done("perf_sat");
    endtask
`endif

    initial begin
        test_reset();
        test_vga_only();
        test_burst_idle();
        test_preempt();
        test_wrap();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef ARB_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
